// File: rtl/writeback_buffer.sv
// writeback_buffer: one-entry eviction buffer between cache and physical memory; reads take priority over drains.
// Define WB_READ_FORWARD_EN to serve read hits straight from the buffered line.
module writeback_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_write,
  input  logic [15:0]  wb_addr,
  input  logic [127:0] wb_wdata,
  output logic         wb_ready,
  input  logic         cache_read,
  input  logic [15:0]  cache_addr,
  output logic [127:0] cache_rdata,
  output logic         cache_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;
`ifdef WB_READ_FORWARD_EN
  localparam state_t hit_next = RESP;
`else
  localparam state_t hit_next = DRAIN;
`endif
  state_t state, state_n;
  logic valid;
  logic [11:0] tag;
  logic [127:0] line, fill;
  logic hit;
  assign hit = valid && cache_addr[15:4] == tag;
  assign wb_ready = ~valid;
  assign cache_resp = state == RESP;
  assign cache_rdata = fill;
  assign pmem_read = state == READ;
  assign pmem_write = state == DRAIN;
  assign pmem_address = pmem_read ? {cache_addr[15:4], 4'h0} : pmem_write ? {tag, 4'h0} : 16'h0;
  assign pmem_wdata = line;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = cache_read ? (hit ? hit_next : READ) : valid ? DRAIN : IDLE;
      READ:  state_n = pmem_resp ? RESP : READ;
      DRAIN: state_n = pmem_resp ? IDLE : DRAIN;
      RESP:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      line  <= '0;
      fill  <= '0;
    end else begin
      if (wb_write && !valid) begin
        valid <= 1'b1;
        tag   <= wb_addr[15:4];
        line  <= wb_wdata;
      end else if (state == DRAIN && pmem_resp)
        valid <= 1'b0;
      if (state == READ && pmem_resp)
        fill <= pmem_rdata;
      else if (state == IDLE && cache_read && hit && hit_next == RESP)
        fill <= line;
    end
  end
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: scoreboard bench; a memory responder pops expected pmem/cache transactions in order.
module tb_writeback_buffer;
  typedef struct packed {logic wr; logic [15:0] addr; logic [127:0] data;} op_t;
  logic clk = 0, reset = 1, wb_write = 0, cache_read = 0, pmem_resp;
  logic [15:0] wb_addr = 0, cache_addr = 0, pmem_address;
  logic [127:0] wb_wdata = 0, pmem_rdata, cache_rdata, pmem_wdata, rd_line = 0;
  logic wb_ready, cache_resp, pmem_read, pmem_write;
  op_t ops[$];
  logic [127:0] rds[$];
  int total = 0, bad = 0, cnt = 0, lat = 1;
  bit late_resp = 0, prev_rd = 0;

  writeback_buffer dut (
    .clk(clk), .reset(reset), .wb_write(wb_write), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_ready(wb_ready), .cache_read(cache_read), .cache_addr(cache_addr), .cache_rdata(cache_rdata),
    .cache_resp(cache_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    pmem_resp = 0;
    pmem_rdata = 0;
    forever begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !pmem_resp && cnt + 1 >= lat) begin
        pmem_resp = 1;
        pmem_rdata = rd_line;
        cnt = 0;
      end else begin
        cnt = ((pmem_read || pmem_write) && !pmem_resp) ? cnt + 1 : 0;
        pmem_resp = late_resp;
      end
      if (prev_rd) begin
        total++;
        if (cache_resp !== 1'b1) begin bad++; $display("FAIL miss_latency cache_resp=%b want=1", cache_resp); end
      end
      prev_rd = 0;
      total++;
      if ((pmem_read && pmem_write) !== 1'b0) begin bad++; $display("FAIL cmd_exclusive rd=%b wr=%b", pmem_read, pmem_write); end
      if (pmem_resp && (pmem_read || pmem_write)) begin
        op_t o;
        total++;
        if (ops.size() == 0) begin
          bad++; $display("FAIL pmem_unexpected wr=%b addr=%h want=none", pmem_write, pmem_address);
        end else begin
          o = ops.pop_front();
          if (o.wr !== pmem_write || o.addr !== pmem_address || (o.wr && o.data !== pmem_wdata)) begin
            bad++; $display("FAIL pmem_op got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                            pmem_write, pmem_address, pmem_wdata, o.wr, o.addr, o.data);
          end
        end
        prev_rd = pmem_read;
      end
      if (cache_resp) begin
        total++;
        if (rds.size() == 0) begin
          bad++; $display("FAIL cache_resp_unexpected data=%h want=none", cache_rdata);
        end else if (rds[0] !== cache_rdata) begin
          bad++; $display("FAIL cache_rdata got=%h want=%h", cache_rdata, rds[0]);
          void'(rds.pop_front());
        end else void'(rds.pop_front());
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) tick();
    total++;
    if ({wb_ready, cache_resp, pmem_read, pmem_write} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000", {wb_ready, cache_resp, pmem_read, pmem_write});
    end
    total++;
    if ({pmem_address, pmem_wdata, cache_rdata} !== '0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want=0", pmem_address, pmem_wdata, cache_rdata);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({cache_resp, pmem_read, pmem_write, wb_ready} !== 4'b0001) begin
        bad++; $display("FAIL idle got=%b want=0001", {cache_resp, pmem_read, pmem_write, wb_ready});
      end
    end
  endtask

  task automatic test_drain;
    lat = 3;
    wb_addr = 16'h1234;
    wb_wdata = {16{8'hA5}};
    wb_write = 1;
    ops.push_back('{wr: 1'b1, addr: 16'h1230, data: {16{8'hA5}}});
    tick();
    wb_write = 0;
    total++;
    if (wb_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%b want=0", wb_ready); end
    tick();
    total++;
    if ({pmem_write, pmem_address} !== {1'b1, 16'h1230}) begin
      bad++; $display("FAIL drain_cmd got wr=%b addr=%h want wr=1 addr=1230", pmem_write, pmem_address);
    end
    for (int i = 0; i < 20 && !(pmem_write && pmem_resp); i++) tick();
    tick();
    total++;
    if ({wb_ready, pmem_write} !== 2'b10) begin
      bad++; $display("FAIL drain_done got ready=%b wr=%b want ready=1 wr=0", wb_ready, pmem_write);
    end
    for (int i = 0; i < 60 && ops.size() + rds.size() != 0; i++) tick();
    total++;
    if (ops.size() + rds.size() != 0) begin bad++; $display("FAIL drain_pending got=%0d want=0", ops.size() + rds.size()); end
  endtask

  task automatic test_read_miss;
    lat = 3;
    rd_line = {4{32'hDEADBEEF}};
    wb_addr = 16'h1230;
    wb_wdata = {16{8'hA5}};
    wb_write = 1;
    cache_addr = 16'h4000;
    cache_read = 1;
    ops.push_back('{wr: 1'b0, addr: 16'h4000, data: '0});
    ops.push_back('{wr: 1'b1, addr: 16'h1230, data: {16{8'hA5}}});
    rds.push_back({4{32'hDEADBEEF}});
    tick();
    wb_write = 0;
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h4000}) begin
      bad++; $display("FAIL miss_cmd got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=4000", pmem_read, pmem_write, pmem_address);
    end
    for (int i = 0; i < 20 && !cache_resp; i++) tick();
    total++;
    if (cache_resp !== 1'b1) begin bad++; $display("FAIL miss_timeout cache_resp=%b want=1", cache_resp); end
    cache_read = 0;
    for (int i = 0; i < 60 && ops.size() + rds.size() != 0; i++) tick();
    tick();
    total++;
    if (cache_rdata !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL miss_hold got=%h want=%h", cache_rdata, {4{32'hDEADBEEF}}); end
    total++;
    if (ops.size() + rds.size() != 0) begin bad++; $display("FAIL miss_pending got=%0d want=0", ops.size() + rds.size()); end
  endtask

  task automatic test_hit;
    logic [127:0] l = 128'h0123456789ABCDEF_FEDCBA9876543210;
    lat = 2;
    rd_line = {8{16'h5A3C}};
    wb_addr = 16'h2220;
    wb_wdata = l;
    wb_write = 1;
    tick();
    wb_write = 0;
    cache_addr = 16'h2226;
    cache_read = 1;
`ifdef WB_READ_FORWARD_EN
    ops.push_back('{wr: 1'b1, addr: 16'h2220, data: l});
    rds.push_back(l);
    tick();
    total++;
    if ({cache_resp, pmem_read, pmem_write, cache_rdata} !== {3'b100, l}) begin
      bad++; $display("FAIL hit_forward got resp=%b rd=%b wr=%b data=%h want 1 0 0 %h", cache_resp, pmem_read, pmem_write, cache_rdata, l);
    end
`else
    ops.push_back('{wr: 1'b1, addr: 16'h2220, data: l});
    ops.push_back('{wr: 1'b0, addr: 16'h2220, data: '0});
    rds.push_back({8{16'h5A3C}});
    tick();
    total++;
    if ({pmem_write, pmem_address} !== {1'b1, 16'h2220}) begin
      bad++; $display("FAIL hit_drain got wr=%b addr=%h want wr=1 addr=2220", pmem_write, pmem_address);
    end
    for (int i = 0; i < 20 && !cache_resp; i++) tick();
    total++;
    if (cache_resp !== 1'b1) begin bad++; $display("FAIL hit_timeout cache_resp=%b want=1", cache_resp); end
`endif
    cache_read = 0;
    for (int i = 0; i < 60 && ops.size() + rds.size() != 0; i++) tick();
    total++;
    if (ops.size() + rds.size() != 0) begin bad++; $display("FAIL hit_pending got=%0d want=0", ops.size() + rds.size()); end
  endtask

  task automatic test_reset_drain;
    lat = 1000;
    wb_addr = 16'h5550;
    wb_wdata = {8{16'hC0DE}};
    wb_write = 1;
    tick();
    wb_write = 0;
    tick();
    total++;
    if (pmem_write !== 1'b1) begin bad++; $display("FAIL rst_drain_start wr=%b want=1", pmem_write); end
    reset = 1;
    tick();
    total++;
    if ({pmem_write, wb_ready} !== 2'b01) begin
      bad++; $display("FAIL rst_drain_drop got wr=%b ready=%b want wr=0 ready=1", pmem_write, wb_ready);
    end
    reset = 0;
    lat = 1;
    late_resp = 1;
    tick();
    late_resp = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({cache_resp, pmem_read, pmem_write, wb_ready} !== 4'b0001) begin
        bad++; $display("FAIL late_resp got=%b want=0001", {cache_resp, pmem_read, pmem_write, wb_ready});
      end
    end
  endtask

  task automatic test_back_to_back;
    lat = 2;
    ops.push_back('{wr: 1'b1, addr: 16'h3000, data: {4{32'hAAAA0001}}});
    ops.push_back('{wr: 1'b1, addr: 16'h3100, data: {4{32'hBBBB0002}}});
    wb_addr = 16'h3000;
    wb_wdata = {4{32'hAAAA0001}};
    wb_write = 1;
    tick();
    total++;
    if (wb_ready !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b want=0", wb_ready); end
    wb_addr = 16'h3100;
    wb_wdata = {4{32'hBBBB0002}};
    for (int i = 0; i < 20 && !wb_ready; i++) tick();
    tick();
    total++;
    if (wb_ready !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b want=0", wb_ready); end
    wb_write = 0;
    for (int i = 0; i < 60 && ops.size() + rds.size() != 0; i++) tick();
    total++;
    if (ops.size() + rds.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", ops.size() + rds.size()); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_read_miss();
    test_hit();
    test_reset_drain();
    test_back_to_back();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
